// File: rtl/mult_share_arb_if.sv
// Request/response and multiplier-operand bundle for mult_share_arb.
// slave: arbiter side; master: the clients plus the shared multiplier.
interface mult_share_arb_if #(
    parameter int unsigned W = 8,
    parameter int unsigned N = 4
);
    localparam int unsigned IdW = $clog2(N);

    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [W-1:0]     m_dA;
    logic [W-1:0]     m_dB;
    logic [2*W-1:0]   m_prod;
    logic [N-1:0]     rsp_valid;
    logic [IdW-1:0]   rsp_id;
    logic [2*W-1:0]   rsp_data;

    modport slave (
        input  req_valid, req_a, req_b, m_prod,
        output req_ready, m_dA, m_dB, rsp_valid, rsp_id, rsp_data
    );

    modport master (
        output req_valid, req_a, req_b, m_prod,
        input  req_ready, m_dA, m_dB, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/mult_share_arb.sv
// Round-robin sharing of one pipelined multiplier among N requesters, with result routing.
// Optional MULT_ARB_STATS_EN adds a saturating handshake counter on o_issue_cnt.
module mult_share_arb #(
    parameter int unsigned W   = 8,
    parameter int unsigned N   = 4,
    parameter int unsigned LAT = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_hold,
`ifdef MULT_ARB_STATS_EN
    output logic [15:0]         o_issue_cnt,
`endif
    mult_share_arb_if.slave     bus
);
    localparam int unsigned IdW = $clog2(N);

    logic [IdW-1:0] r_ptr;
    logic [W-1:0]   r_da;
    logic [W-1:0]   r_db;
    logic [N-1:0]   w_gnt;
    logic           w_fire;
    logic [IdW-1:0] w_gnt_id;
    logic [IdW-1:0] w_cand;

    // Stage 0 lines up with the operand registers; stage LAT lines up with m_prod.
    logic [LAT:0]   r_tag_vld;
    logic [IdW-1:0] r_tag_id [LAT+1];

    always_comb begin
        w_gnt    = '0;
        w_fire   = 1'b0;
        w_gnt_id = '0;
        w_cand   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            w_cand = IdW'((32'(r_ptr) + k) % N);
            if (!i_hold && !w_fire && bus.req_valid[w_cand]) begin
                w_fire   = 1'b1;
                w_gnt_id = w_cand;
            end
        end
        if (w_fire) begin
            w_gnt[w_gnt_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
            r_da  <= '0;
            r_db  <= '0;
        end else if (w_fire) begin
            r_ptr <= (w_gnt_id == IdW'(N - 1)) ? '0 : w_gnt_id + IdW'(1);
            r_da  <= bus.req_a[32'(w_gnt_id) * W +: W];
            r_db  <= bus.req_b[32'(w_gnt_id) * W +: W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_vld <= '0;
            for (int unsigned j = 0; j <= LAT; j++) begin
                r_tag_id[j] <= '0;
            end
        end else begin
            r_tag_vld   <= {r_tag_vld[LAT-1:0], w_fire};
            r_tag_id[0] <= w_gnt_id;
            for (int unsigned j = 1; j <= LAT; j++) begin
                r_tag_id[j] <= r_tag_id[j-1];
            end
        end
    end

`ifdef MULT_ARB_STATS_EN
    logic [15:0] r_issue_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issue_cnt <= '0;
        end else if (w_fire && (r_issue_cnt != 16'hFFFF)) begin
            r_issue_cnt <= r_issue_cnt + 16'd1;
        end
    end

    assign o_issue_cnt = r_issue_cnt;
`endif

    assign bus.req_ready = w_gnt;
    assign bus.m_dA      = r_da;
    assign bus.m_dB      = r_db;
    assign bus.rsp_valid = r_tag_vld[LAT] ? (N'(1) << r_tag_id[LAT]) : '0;
    assign bus.rsp_id    = r_tag_vld[LAT] ? r_tag_id[LAT] : '0;
    assign bus.rsp_data  = bus.m_prod;
endmodule
